// File: rtl/galaksija_pkg.sv
// Boot sequencer shared types: state codes and counter width.
// Imported by the sequencer top and its debounce sub-module.
package galaksija_pkg;

  localparam int C_cnt_w = 26;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_BTN       = 3'd4,
    ST_LOADER    = 3'd5
  } boot_state_t;

endpackage

// File: rtl/galaksija_boot_seq_if.sv
// Sequencer outputs towards core, video path, ESP32 strap and LEDs.
// master: sequencer drives; slave: consumers read.
interface galaksija_boot_seq_if;
  logic       sys_reset_n;
  logic       video_en;
  logic       wifi_gpio0;
  logic       btn_pressed;
  logic [2:0] state_o;

  modport master (
    output sys_reset_n, video_en, wifi_gpio0,
    output btn_pressed, state_o
  );

  modport slave (
    input sys_reset_n, video_en, wifi_gpio0,
    input btn_pressed, state_o
  );
endinterface

// File: rtl/galaksija_boot_seq_btn_debounce.sv
// btn_n synchronizer plus debouncer; btn_pressed is active-high.
// Ports: clk, reset_n (sync, active-low), btn_n (async), btn_pressed.
module btn_debounce
  import galaksija_pkg::*;
#(
  parameter int C_sync_stages = 2,
  parameter int C_debounce    = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_n,
  output logic btn_pressed
);

  localparam int W = $clog2(C_debounce + 1);
  localparam logic [W-1:0] LIM = W'(C_debounce - 1);

  logic [C_sync_stages-1:0] sync;
  logic [W-1:0]             cnt;
  logic                     lvl;

  assign lvl = ~sync[C_sync_stages-1];

  // cnt counts consecutive cycles where the input disagrees
  // with the accepted level; any agreement restarts it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync        <= '1;
      cnt         <= '0;
      btn_pressed <= 1'b0;
    end else begin
      sync <= {sync[C_sync_stages-2:0], btn_n};
      if (lvl == btn_pressed) begin
        cnt <= '0;
      end else if (cnt == LIM) begin
        btn_pressed <= lvl;
        cnt         <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/galaksija_boot_seq.sv
// Boot/reset sequencer: PLL lock settle, core reset hold, loader strap.
// Ports: clk, reset_n (sync), locked, btn_n (async), boot (outputs).
module galaksija_boot_seq
  import galaksija_pkg::*;
#(
  parameter int C_sync_stages = 2,
  parameter int C_lock_settle = 1024,
  parameter int C_reset_hold  = 256,
  parameter int C_debounce    = 250000,
  parameter int C_long_press  = 50000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic locked,
  input  logic btn_n,
  galaksija_boot_seq_if.master boot
);

  localparam logic [C_cnt_w-1:0] LIM_SETTLE =
    C_cnt_w'(C_lock_settle - 1);
  localparam logic [C_cnt_w-1:0] LIM_HOLD =
    C_cnt_w'(C_reset_hold - 1);
  localparam logic [C_cnt_w-1:0] LIM_LONG =
    C_cnt_w'(C_long_press - 1);

  logic [C_sync_stages-1:0] lock_sync;
  logic                     lock_s;
  boot_state_t              state;
  boot_state_t              state_nxt;
  logic [C_cnt_w-1:0]       cnt;
  logic                     btn_pressed;
  logic                     btn_prev;

  btn_debounce #(
    .C_sync_stages (C_sync_stages),
    .C_debounce    (C_debounce)
  ) u_dbn (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_n       (btn_n),
    .btn_pressed (btn_pressed)
  );

  assign lock_s = lock_sync[C_sync_stages-1];

  // Counter restarts on every state change and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_sync <= '0;
      state     <= ST_WAIT_LOCK;
      cnt       <= '0;
      btn_prev  <= 1'b0;
    end else begin
      lock_sync <= {lock_sync[C_sync_stages-2:0], locked};
      state     <= state_nxt;
      btn_prev  <= btn_pressed;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_WAIT_LOCK: if (lock_s) state_nxt = ST_SETTLE;
      ST_SETTLE:
        if (cnt == LIM_SETTLE) state_nxt = ST_HOLD;
      ST_HOLD:
        if (cnt == LIM_HOLD) state_nxt = ST_RUN;
      ST_RUN:
        if (btn_pressed && !btn_prev) state_nxt = ST_BTN;
      // A debounced release wins over reaching the long-press limit.
      ST_BTN: begin
        if (!btn_pressed) begin
          state_nxt = ST_HOLD;
        end else if (cnt == LIM_LONG) begin
          state_nxt = ST_LOADER;
        end
      end
      ST_LOADER:
        if (!btn_pressed) state_nxt = ST_HOLD;
      default: state_nxt = ST_WAIT_LOCK;
    endcase
    // Lock loss overrides every other transition.
    if (!lock_s && state != ST_WAIT_LOCK) begin
      state_nxt = ST_WAIT_LOCK;
    end
  end

  always_comb begin
    boot.sys_reset_n = 1'b0;
    boot.video_en    = 1'b0;
    boot.wifi_gpio0  = 1'b1;
    unique case (1'b1)
      (state == ST_RUN): begin
        boot.sys_reset_n = 1'b1;
        boot.video_en    = 1'b1;
      end
      (state == ST_HOLD),
      (state == ST_BTN): boot.video_en = 1'b1;
      (state == ST_LOADER): begin
        boot.video_en   = 1'b1;
        boot.wifi_gpio0 = 1'b0;
      end
      default: ;
    endcase
  end

  assign boot.btn_pressed = btn_pressed;
  assign boot.state_o     = state;

endmodule

// File: tb/tb_galaksija_boot_seq.sv
// Self-checking bench for galaksija_boot_seq with a timeline model.
// Drives random/directed locked, btn_n, reset_n; compares every cycle.
module tb_galaksija_boot_seq;

  localparam int C_S  = 2;
  localparam int C_L  = 8;
  localparam int C_H  = 4;
  localparam int C_D  = 4;
  localparam int C_LP = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic locked = 1'b0;
  logic btn_n = 1'b1;

  galaksija_boot_seq_if boot ();

  galaksija_boot_seq #(
    .C_sync_stages (C_S),
    .C_lock_settle (C_L),
    .C_reset_hold  (C_H),
    .C_debounce    (C_D),
    .C_long_press  (C_LP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .locked  (locked),
    .btn_n   (btn_n),
    .boot    (boot)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int t = 0;

  // Model: phase number, edge index at which it was entered,
  // delayed input histories and the debounced level.
  int m_ph = 0;
  int m_te = 0;
  logic [C_S-1:0] m_lk = '0;
  logic [C_S-1:0] m_bs = '1;
  logic m_pr = 1'b0;
  logic m_pv = 1'b0;
  int m_st = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h exp=%0h",
               tag, t, got, exp);
    end
  endtask

  task automatic model_step();
    int n;
    int np;
    logic lk;
    logic lvl;
    if (!reset_n) begin
      m_ph = 0;
      m_te = t;
      m_lk = '0;
      m_bs = '1;
      m_pr = 1'b0;
      m_pv = 1'b0;
      m_st = 0;
    end else begin
      n  = t - m_te;
      lk = m_lk[C_S-1];
      np = m_ph;
      if (m_ph != 0 && !lk) np = 0;
      else begin
        case (m_ph)
          0: np = lk ? 1 : 0;
          1: np = (n >= C_L) ? 2 : 1;
          2: np = (n >= C_H) ? 3 : 2;
          3: np = (m_pr && !m_pv) ? 4 : 3;
          4: np = !m_pr ? 2 : ((n >= C_LP) ? 5 : 4);
          default: np = !m_pr ? 2 : 5;
        endcase
      end
      if (np != m_ph) begin
        m_ph = np;
        m_te = t;
      end
      lvl  = !m_bs[C_S-1];
      m_pv = m_pr;
      if (lvl != m_pr) begin
        m_st++;
        if (m_st == C_D) begin
          m_pr = lvl;
          m_st = 0;
        end
      end else m_st = 0;
      m_lk = {m_lk[C_S-2:0], locked};
      m_bs = {m_bs[C_S-2:0], btn_n};
    end
  endtask

  task automatic cyc();
    t++;
    model_step();
    @(posedge clk);
    #1;
    chk("m_state", 32'(boot.state_o), 32'(m_ph));
    chk("m_sysr", 32'(boot.sys_reset_n), 32'(m_ph == 3));
    chk("m_ven", 32'(boot.video_en), 32'(m_ph >= 2));
    chk("m_wifi", 32'(boot.wifi_gpio0), 32'(m_ph != 5));
    chk("m_btn", 32'(boot.btn_pressed), 32'(m_pr));
  endtask

  task automatic boot_check();
    int k;
    locked = 1'b1;
    k = t;
    repeat (C_S + C_L + C_H + 2) begin
      cyc();
      if (t == k + C_S + C_L)
        chk("boot_ven_pre", 32'(boot.video_en), 0);
      if (t == k + C_S + 1 + C_L)
        chk("boot_ven", 32'(boot.video_en), 1);
      if (t == k + C_S + C_L + C_H)
        chk("boot_sysr_pre", 32'(boot.sys_reset_n), 0);
      if (t == k + C_S + 1 + C_L + C_H) begin
        chk("boot_sysr", 32'(boot.sys_reset_n), 1);
        chk("boot_wifi", 32'(boot.wifi_gpio0), 1);
      end
    end
  endtask

  task automatic press(int d);
    int p;
    logic lng;
    lng = (d > C_LP);
    btn_n = 1'b0;
    p = t;
    while (t < p + d + 12) begin
      cyc();
      if (t == p + d) btn_n = 1'b1;
      if (t == p + 6)
        chk("pr_pre", 32'(boot.state_o), 3);
      if (t == p + 7) begin
        chk("pr_btn", 32'(boot.state_o), 4);
        chk("pr_sysr", 32'(boot.sys_reset_n), 0);
      end
      if (lng && t == p + 6 + C_LP)
        chk("lp_btn", 32'(boot.state_o), 4);
      if (lng && t == p + 7 + C_LP) begin
        chk("lp_ldr", 32'(boot.state_o), 5);
        chk("lp_wifi", 32'(boot.wifi_gpio0), 0);
      end
      if (lng && t == p + d + 6) begin
        chk("lp_ldr_end", 32'(boot.state_o), 5);
        chk("lp_wifi_end", 32'(boot.wifi_gpio0), 0);
      end
      if (!lng && t == p + d + 6)
        chk("sp_btn_end", 32'(boot.state_o), 4);
      if (t == p + d + 7) begin
        chk("rel_hold", 32'(boot.state_o), 2);
        chk("rel_wifi", 32'(boot.wifi_gpio0), 1);
      end
      if (t == p + d + 10)
        chk("rel_hold2", 32'(boot.state_o), 2);
      if (t == p + d + 11)
        chk("rel_run", 32'(boot.state_o), 3);
    end
  endtask

  initial begin
    int run;
    logic lvl;
    repeat (3) cyc();
    chk("rst_sysr", 32'(boot.sys_reset_n), 0);
    chk("rst_ven", 32'(boot.video_en), 0);
    chk("rst_wifi", 32'(boot.wifi_gpio0), 1);
    chk("rst_btn", 32'(boot.btn_pressed), 0);
    chk("rst_state", 32'(boot.state_o), 0);
    reset_n = 1'b1;
    repeat ($urandom_range(2, 6)) cyc();
    boot_check();

    // bounce: stable runs always shorter than the debounce window
    lvl = 1'b0;
    run = 0;
    repeat (40) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = $urandom_range(1, 3);
      end
      btn_n = lvl;
      run--;
      cyc();
      chk("bn_btn", 32'(boot.btn_pressed), 0);
      chk("bn_state", 32'(boot.state_o), 3);
    end
    btn_n = 1'b1;
    repeat (6) cyc();

    press($urandom_range(5, 20));
    press(C_LP);
    press(C_LP + 1);
    press($urandom_range(45, 70));

    // lock loss in RUN
    locked = 1'b0;
    repeat (2) cyc();
    chk("rg_sysr_pre", 32'(boot.sys_reset_n), 1);
    cyc();
    chk("rg_sysr", 32'(boot.sys_reset_n), 0);
    chk("rg_ven", 32'(boot.video_en), 0);
    boot_check();

    // lock glitch in SETTLE
    locked = 1'b0;
    repeat (3) cyc();
    locked = 1'b1;
    repeat (5) cyc();
    chk("sg_settle", 32'(boot.state_o), 1);
    locked = 1'b0;
    repeat (3) cyc();
    chk("sg_wait", 32'(boot.state_o), 0);
    boot_check();

    // reset while in LOADER
    btn_n = 1'b0;
    repeat (7 + C_LP + 3) cyc();
    chk("mr_ldr", 32'(boot.state_o), 5);
    reset_n = 1'b0;
    cyc();
    chk("mr_sysr", 32'(boot.sys_reset_n), 0);
    chk("mr_ven", 32'(boot.video_en), 0);
    chk("mr_wifi", 32'(boot.wifi_gpio0), 1);
    chk("mr_btn", 32'(boot.btn_pressed), 0);
    chk("mr_state", 32'(boot.state_o), 0);
    reset_n = 1'b1;
    repeat (10) cyc();
    btn_n = 1'b1;
    repeat (20) cyc();
    chk("mr_run", 32'(boot.state_o), 3);

    // random soak against the model
    run = 0;
    repeat (1500) begin
      if (locked && $urandom_range(0, 199) == 0) locked = 1'b0;
      else if (!locked && $urandom_range(0, 3) == 0)
        locked = 1'b1;
      if (run == 0) begin
        btn_n = ~btn_n;
        run = $urandom_range(1, 80);
      end
      run--;
      reset_n = ($urandom_range(0, 499) != 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
